// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per
// clock over LOG2N stages, natural-order unload with last marker.
module fft_r2_iter #(
    parameter int unsigned NFFT   = 8,
    parameter int unsigned LOG2N  = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TW_W   = 16,
    parameter int unsigned SCALE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last,
    output logic              complete,
    output logic [1:0]        fft_state
);

    localparam int unsigned SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int unsigned BW = LOG2N - 1;
    localparam int unsigned EW = DATA_W + 2;
    localparam int unsigned PW = DATA_W + TW_W + 1;

    localparam logic [LOG2N-1:0] LastIdx   = LOG2N'(NFFT - 1);
    localparam logic [BW-1:0]    LastBfly  = BW'(NFFT / 2 - 1);
    localparam logic [SW-1:0]    LastStage = SW'(LOG2N - 1);
    localparam logic signed [EW-1:0] SatMax = {3'b000, {(DATA_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] SatMin = {3'b111, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StCompute = 2'd1,
        StUnload  = 2'd2
    } state_e;

    // Twiddle coefficient in Q1.(TW_W-1); im selects the -sin part.
    // Taylor series keeps this a pure elaboration-time computation.
    function automatic int tw_coef(input int k, input bit im);
        real th, term, c, s, full, v;
        int  r;
        th   = 2.0 * 3.14159265358979323846 * real'(k) / real'(NFFT);
        c    = 0.0;
        s    = 0.0;
        term = 1.0;
        for (int n = 0; n < 40; n++) begin
            case (n % 4)
                0:       c = c + term;
                1:       s = s + term;
                2:       c = c - term;
                default: s = s - term;
            endcase
            term = term * th / real'(n + 1);
        end
        full = 1.0;
        for (int i = 0; i < int'(TW_W) - 1; i++) full = full * 2.0;
        v = im ? -s * full : c * full;
        // Round half away from zero; +1.0 clips to the largest positive code.
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r >= $rtoi(full)) r = $rtoi(full) - 1;
        return r;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) r[i] = v[int'(LOG2N) - 1 - i];
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [EW-1:0] v);
        if (SCALE != 0) return DATA_W'(v >>> 1);
        if (v > SatMax) return SatMax[DATA_W-1:0];
        if (v < SatMin) return SatMin[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic signed [TW_W-1:0] tw_re [NFFT/2];
    logic signed [TW_W-1:0] tw_im [NFFT/2];

    for (genvar g = 0; g < int'(NFFT / 2); g++) begin : g_tw
        localparam int TwRe = tw_coef(g, 1'b0);
        localparam int TwIm = tw_coef(g, 1'b1);
        assign tw_re[g] = TW_W'(TwRe);
        assign tw_im[g] = TW_W'(TwIm);
    end

    logic signed [DATA_W-1:0] mem_i [NFFT];
    logic signed [DATA_W-1:0] mem_q [NFFT];

    state_e           state_q;
    logic [LOG2N-1:0] cnt_q;
    logic [SW-1:0]    stage_q;
    logic [BW-1:0]    bfly_q;
    logic             in_ready_q, out_valid_q, complete_q;

    int                     s_v, j_v, half_v, pos_v, a_v;
    logic [LOG2N-1:0]       a_idx, b_idx;
    logic [BW-1:0]          k_idx;
    logic signed [PW-1:0]   p_re, p_im;
    logic signed [EW-1:0]   t_re, t_im;
    logic signed [DATA_W-1:0] na_i, na_q, nb_i, nb_q;

    // Butterfly addressing, twiddle multiply and write-back values.
    always_comb begin
        s_v    = int'(stage_q);
        j_v    = int'(bfly_q);
        half_v = 1 << s_v;
        pos_v  = j_v & (half_v - 1);
        a_v    = ((j_v >> s_v) << (s_v + 1)) + pos_v;
        a_idx  = LOG2N'(a_v);
        b_idx  = LOG2N'(a_v + half_v);
        k_idx  = BW'(pos_v << (int'(LOG2N) - 1 - s_v));
        p_re   = PW'(mem_i[b_idx]) * PW'(tw_re[k_idx]) - PW'(mem_q[b_idx]) * PW'(tw_im[k_idx]);
        p_im   = PW'(mem_i[b_idx]) * PW'(tw_im[k_idx]) + PW'(mem_q[b_idx]) * PW'(tw_re[k_idx]);
        if (k_idx == '0) begin
            t_re = EW'(mem_i[b_idx]);
            t_im = EW'(mem_q[b_idx]);
        end else begin
            t_re = EW'(p_re >>> (TW_W - 1));
            t_im = EW'(p_im >>> (TW_W - 1));
        end
        na_i = narrow(EW'(mem_i[a_idx]) + t_re);
        na_q = narrow(EW'(mem_q[a_idx]) + t_im);
        nb_i = narrow(EW'(mem_i[a_idx]) - t_re);
        nb_q = narrow(EW'(mem_q[a_idx]) - t_im);
    end

    // Sample storage: bit-reversed writes in LOAD, in-place butterflies in COMPUTE.
    always_ff @(posedge clk) begin
        if (in_ready_q && in_valid) begin
            mem_i[bitrev(cnt_q)] <= in_i;
            mem_q[bitrev(cnt_q)] <= in_q;
        end else if (state_q == StCompute) begin
            mem_i[a_idx] <= na_i;
            mem_q[a_idx] <= na_q;
            mem_i[b_idx] <= nb_i;
            mem_q[b_idx] <= nb_q;
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            stage_q     <= '0;
            bfly_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                StLoad: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        cnt_q <= cnt_q + LOG2N'(1);
                        if (cnt_q == LastIdx) begin
                            state_q    <= StCompute;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StCompute: begin
                    bfly_q <= bfly_q + BW'(1);
                    if (bfly_q == LastBfly) begin
                        bfly_q <= '0;
                        if (stage_q == LastStage) begin
                            stage_q     <= '0;
                            state_q     <= StUnload;
                            complete_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            stage_q <= stage_q + SW'(1);
                        end
                    end
                end
                StUnload: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + LOG2N'(1);
                        if (cnt_q == LastIdx) begin
                            state_q     <= StLoad;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign complete  = complete_q;
    assign fft_state = state_q;
    assign out_i     = out_valid_q ? mem_i[cnt_q] : '0;
    assign out_q     = out_valid_q ? mem_q[cnt_q] : '0;
    assign out_index = out_valid_q ? cnt_q : '0;
    assign out_last  = out_valid_q && (cnt_q == LastIdx);

endmodule

// File: doc/fft_r2_iter.md
# fft_r2_iter

Parametrised, frame-based radix-2 decimation-in-time FFT core for the OFDM receive/transmit chain.
- Replaces the fixed two-point butterfly bank with one in-place iterative engine, generic in transform size and sample width.
- Accepts NFFT complex samples over a valid/ready stream, computes the transform with one butterfly per clock, and streams the bins out in natural order with a last marker.
- Optional per-stage scaling keeps the result in range.

## Interface
- NFFT, 8, transform size; power of two, 4..1024
- LOG2N, 3, log2(NFFT); must match NFFT
- DATA_W, 16, two's-complement I/Q sample width
- TW_W, 16, twiddle width, signed Q1.(TW_W-1)
- SCALE, 1, 1: arithmetic shift right by 1 after every stage; 0: no shift, saturate to DATA_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  core accepts a sample (LOAD state only)
- in_i, in_q  in  DATA_W each  input sample, time order
- out_valid  out  1  output bin valid (UNLOAD state only)
- out_ready  in  1  downstream accepts a bin
- out_i, out_q  out  DATA_W each  output bin
- out_index  out  LOG2N  bin number of the current output
- out_last  out  1  high with bin NFFT-1
- complete  out  1  one-cycle pulse when the last butterfly is written
- fft_state  out  2  current state: 0 LOAD, 1 COMPUTE, 2 UNLOAD

## Operation
- Storage is an NFFT-entry register array of complex words. Reads are combinational; writes are registered.
- States are LOAD, COMPUTE and UNLOAD. Reset enters LOAD with the counters at 0.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready handshake writes the sample to address bitrev(cnt), then increments cnt.
  - After the NFFT-th handshake, the state moves to COMPUTE and cnt clears.
- COMPUTE:
  - Runs for stage s = 0..LOG2N-1 and butterfly j = 0..NFFT/2-1, one butterfly per cycle.
  - Addressing: half = 2^s, pos = j & (half-1), a = ((j>>s)<<(s+1)) + pos, b = a + half, twiddle index k = pos << (LOG2N-1-s).
  - Twiddle: W_k = cos(2πk/NFFT) − j·sin(2πk/NFFT). It is held in a ROM of NFFT/2 entries, built by a constant function at elaboration.
  - Values are rounded to nearest. +1.0 saturates to 2^(TW_W-1)-1.
- Butterfly:
  - If k = 0, the multiply is bypassed: t = B exactly.
  - Otherwise t = B·W_k. The complex product is held at full precision, then arithmetically shifted right by TW_W-1 (truncation).
  - A' = A + t and B' = A − t, computed at DATA_W+2 bits.
  - SCALE = 1: shift right arithmetically by 1, then keep DATA_W bits.
  - SCALE = 0: saturate to [−2^(DATA_W-1), 2^(DATA_W-1)-1].
  - A' and B' write back to addresses a and b on the same edge.
- After the last butterfly, complete pulses and the state moves to UNLOAD.
- UNLOAD:
  - out_valid = 1; out_i/out_q = mem[cnt]; out_index = cnt; out_last = (cnt == NFFT-1).
  - cnt increments on out_valid & out_ready.
  - After the handshake with out_last high, the state returns to LOAD.
- Input is ignored outside LOAD (in_ready = 0). Output holds steady while out_ready is low.

## Timing
- Reset values: in_ready = 0 while rst_n is low, then 1 from the first cycle after release. All other outputs are 0; fft_state = 0.
- Reset asserted in any state clears the state and counters immediately and discards the frame. Memory contents are don't-care.
- LOAD takes NFFT accepted handshakes; bubbles on in_valid are allowed.
- COMPUTE takes exactly (NFFT/2)·LOG2N cycles; NFFT = 8 gives 12 cycles.
- complete is high in the cycle fft_state first reads 2.
- The first out_valid is in the same cycle as complete. With out_ready held high, NFFT consecutive bins follow.
- Minimum frame period: 2·NFFT + (NFFT/2)·LOG2N cycles.
- No overlap between frames. The next frame's in_ready rises the cycle after the out_last handshake.

## Test plan
- **DC frame.** NFFT = 8, SCALE = 1, all samples (8000, 0), out_ready = 1.
  - Bin 0 = (8000, 0) exactly; bins 1..7 = (0, 0) exactly.
  - complete occurs 12 cycles after the 8th input handshake.
- **Impulse.** x[0] = (16384, 0), others 0.
  - Every bin = (2048, 0) within ±LOG2N LSB.
  - out_index runs 0..7; out_last is high only at index 7.
- **Single tone.** x[n] = 8192·e^(j2πn/8).
  - Bin 1 = (8192, 0) ±3 LSB; all other bins |·| ≤ 3.
- **Handshake stress.** Random in_valid gaps and random out_ready stalls.
  - Results match the unstalled run bit-exactly.
  - in_ready = 0 throughout COMPUTE and UNLOAD; out_i/out_q stable while stalled.
- **Saturation, SCALE = 0.** All samples (32767, 0).
  - Bin 0 = (32767, 0); others 0.
- **Reset mid-operation.** rst_n is pulsed low during COMPUTE.
  - Outputs are 0 immediately and fft_state = 0.
  - A following DC frame gives the correct result.
